md_unit: RTL and testbench
==========================

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 The block SHALL use one clock and one reset; reset is asynchronous and active-low.
REQ-002 The port `clk` SHALL be an input, 1 bit wide, and SHALL be the rising-edge clock.
REQ-003 The port `reset` SHALL be an input, 1 bit wide, asynchronous, active-low (0 = reset).
REQ-004 The port `MDop` SHALL be an input, 4 bits wide, carrying the E-stage MD command from the decoder.
REQ-005 The port `A` SHALL be an input, 32 bits wide: the forwarded rs operand.
REQ-006 The port `B` SHALL be an input, 32 bits wide: the forwarded rt operand.
REQ-007 The port `start` SHALL be an output, 1 bit wide, high in a cycle where a mult/multu/div/divu is accepted.
REQ-008 The port `busy` SHALL be an output, 1 bit wide, high while an accepted operation is in flight.
REQ-009 The port `HI` SHALL be an output, 32 bits wide, and SHALL be the architectural HI register.
REQ-010 The port `LO` SHALL be an output, 32 bits wide, and SHALL be the architectural LO register.
REQ-011 The port `MDout` SHALL be an output, 32 bits wide, carrying the mfhi/mflo read data.

Function
REQ-012 MDop encodings SHALL be: nop=0, mult=1, multu=2, div=3, divu=4, mfhi=5, mflo=6, mthi=7, mtlo=8; codes 9-15 SHALL be treated as nop.
REQ-013 `start` SHALL be combinational and SHALL equal (MDop in {mult, multu, div, divu}) AND NOT busy.
REQ-014 FSM states SHALL be IDLE and RUN; IDLE->RUN on start; RUN->IDLE on the edge where the counter equals 1.
REQ-015 On start, the block SHALL load the counter with 5 for mult/multu and 10 for div/divu, and SHALL latch the operation and both operands.
REQ-016 `busy` SHALL be registered: high exactly N cycles (5 or 10) starting the cycle after start.
REQ-017 HI/LO SHALL update on the clock edge that ends the last busy cycle; an mfhi/mflo in the following cycle SHALL return the new value.
REQ-018 For mult, {HI,LO} SHALL be the signed 64-bit product; for multu, the unsigned 64-bit product.
REQ-019 For div, LO SHALL be the quotient truncated toward zero and HI the remainder with the sign of the dividend; divu SHALL behave the same way, unsigned.
REQ-020 Divide by zero (B=0) SHALL leave HI and LO unchanged; busy timing SHALL be unaffected.
REQ-021 div of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-022 mthi/mtlo SHALL write A into HI/LO at the clock edge when not busy.
REQ-023 While busy, any non-nop MDop other than mfhi/mflo SHALL be ignored; the hazard unit guarantees a stall, and the bench SHALL flag the violation.
REQ-024 `MDout` SHALL be combinational: HI for mfhi, LO for mflo, otherwise 0; during busy it SHALL return the old HI/LO.
REQ-025 A start in the cycle right after busy falls SHALL be accepted, with no bubble.

Reset
REQ-026 When reset=0, HI, LO, the counter and latched operands SHALL be set to 0, the FSM SHALL go to IDLE, and busy SHALL be 0, all asynchronously.
REQ-027 Reset during RUN SHALL abandon the operation with no HI/LO commit; start SHALL depend only on MDop after reset release.

Structure
REQ-028 The MDop codes and the latency constants (MULT_CYC=5, DIV_CYC=10) SHALL live in the shared macro/package file used by the decoder.
REQ-029 The block SHALL be a single module with no sub-module; the arithmetic SHALL be computed at start into pending-result registers and committed at the end of the count.

Verification
REQ-030 The bench SHALL cover: mult A=0xFFFFFFFE, B=3 -> busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu with the same operands -> HI=0x2, LO=0xFFFFFFFA.
REQ-031 The bench SHALL cover: div A=-7, B=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=2 -> LO=3, HI=1.
REQ-032 The bench SHALL cover: mthi A=0x1234 then divu B=0 -> after 10 busy cycles HI=0x1234, LO unchanged; mfhi -> MDout=0x1234.
REQ-033 The bench SHALL cover: mult issued, mflo during busy -> old LO returned; mflo in the cycle after busy -> new LO returned.
REQ-034 The bench SHALL cover: reset asserted at busy cycle 3 of div -> busy=0 immediately, HI=LO=0, no later commit.
REQ-035 The bench SHALL cover: back-to-back mult, then div issued the first cycle busy=0 -> start=1, and busy stays high for 10 more cycles with no gap.

Source files
------------

// File: rtl/md_unit_pkg.sv
// Shared MD command encodings, latency constants and state type, also used by the decoder.
// Latency: none (definitions only).
// Backpressure: none.
package md_unit_pkg;

  // E-stage MD command encodings from the decoder; codes 9-15 act as nop.
  typedef enum logic [3:0] {
    MD_NOP   = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  // Busy cycles per accepted operation.
  localparam logic [3:0] MULT_CYC = 4'd5;
  localparam logic [3:0] DIV_CYC  = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  function automatic logic is_start_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// Bundle between the E stage and the multiply/divide unit.
// Latency: none (wires only).
// Backpressure: busy from the unit tells the hazard logic to stall MD commands.
// Ports: MDop/A/B from the pipeline (master); start/busy/HI/LO/MDout from the unit (slave).
interface md_if;
  logic [3:0]  MDop;
  logic [31:0] A;
  logic [31:0] B;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDout;

  modport master (output MDop, A, B, input start, busy, HI, LO, MDout);
  modport slave  (input MDop, A, B, output start, busy, HI, LO, MDout);
endinterface

// File: rtl/md_unit.sv
// Multiply/divide unit owning the HI/LO registers; result computed at start, committed after the count.
// Latency: start -> busy for 5 (mult/multu) or 10 (div/divu) cycles -> HI/LO visible the next cycle.
// Backpressure: start only when not busy; MD writes while busy are dropped (hazard unit stalls them).
// Ports: clk, reset (async active-low), md (slave side of md_if: MDop/A/B in, start/busy/HI/LO/MDout out).
module md_unit
  import md_unit_pkg::*;
(
  input  logic clk,
  input  logic reset,
  md_if.slave  md
);

  md_state_e   r_state;
  logic        r_busy;
  logic [3:0]  r_cnt;
  md_op_e      r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic               w_start;
  logic signed [63:0] w_sa64;
  logic signed [63:0] w_sb64;
  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;
  logic [31:0]        w_divs_b;
  logic [31:0]        w_divu_b;
  logic signed [31:0] w_q_s;
  logic signed [31:0] w_r_s;
  logic [31:0]        w_q_u;
  logic [31:0]        w_r_u;
  logic [31:0]        w_pend_hi;
  logic [31:0]        w_pend_lo;
  logic               w_div_zero;
  logic               w_div_ovf;

  always_comb begin
    w_start  = is_start_op(md.MDop) && !r_busy;
    w_sa64   = {{32{md.A[31]}}, md.A};
    w_sb64   = {{32{md.B[31]}}, md.B};
    w_prod_s = w_sa64 * w_sb64;
    w_prod_u = {32'd0, md.A} * {32'd0, md.B};
    // Divisors are substituted only to keep the arithmetic defined; the
    // zero-divide and signed-overflow cases are resolved at commit.
    w_divu_b = (md.B == 32'd0) ? 32'd1 : md.B;
    w_divs_b = ((md.B == 32'd0) || (md.A == 32'h8000_0000 && md.B == 32'hFFFF_FFFF))
               ? 32'd1 : md.B;
    w_q_s    = $signed(md.A) / $signed(w_divs_b);
    w_r_s    = $signed(md.A) % $signed(w_divs_b);
    w_q_u    = md.A / w_divu_b;
    w_r_u    = md.A % w_divu_b;

    w_pend_hi = 32'd0;
    w_pend_lo = 32'd0;
    case (md.MDop)
      MD_MULT:  {w_pend_hi, w_pend_lo} = w_prod_s;
      MD_MULTU: {w_pend_hi, w_pend_lo} = w_prod_u;
      MD_DIV:   begin w_pend_hi = w_r_s; w_pend_lo = w_q_s; end
      MD_DIVU:  begin w_pend_hi = w_r_u; w_pend_lo = w_q_u; end
      default:  ;
    endcase

    w_div_zero = is_div_op(r_op) && (r_b == 32'd0);
    w_div_ovf  = (r_op == MD_DIV) && (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_cnt     <= 4'd0;
      r_op      <= MD_NOP;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state   <= ST_RUN;
            r_busy    <= 1'b1;
            r_cnt     <= is_div_op(md.MDop) ? DIV_CYC : MULT_CYC;
            r_op      <= md_op_e'(md.MDop);
            r_a       <= md.A;
            r_b       <= md.B;
            r_pend_hi <= w_pend_hi;
            r_pend_lo <= w_pend_lo;
          end else if (md.MDop == MD_MTHI) begin
            r_hi <= md.A;
          end else if (md.MDop == MD_MTLO) begin
            r_lo <= md.A;
          end
        end
        ST_RUN: begin
          // Any MD write arriving here is dropped; only the count advances.
          if (r_cnt == 4'd1) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            if (w_div_ovf) begin
              r_hi <= 32'd0;
              r_lo <= 32'h8000_0000;
            end else if (!w_div_zero) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign md.start = w_start;
  assign md.busy  = r_busy;
  assign md.HI    = r_hi;
  assign md.LO    = r_lo;
  // Reads see the committed HI/LO, so during busy they return the old values.
  assign md.MDout = (md.MDop == MD_MFHI) ? r_hi :
                    (md.MDop == MD_MFLO) ? r_lo : 32'd0;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: vector table plus hand-written multi-cycle sequences.
// Latency: inputs driven on the falling edge, outputs sampled 1ns later.
// Backpressure: bench never issues MD writes while busy and flags it if that happens.
module tb_md_unit;
  import md_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  md_if u_if ();

  md_unit dut (
    .clk   (clk),
    .reset (reset),
    .md    (u_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called on a falling edge: issues op, then counts busy cycles; returns on
  // the falling edge of the first non-busy cycle.
  task automatic run_op(input string name, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input int exp_cyc);
    int cnt;
    u_if.MDop = op;
    u_if.A    = a;
    u_if.B    = b;
    #1;
    chk({name, "_start"}, 32'(u_if.start), 32'd1);
    @(negedge clk);
    u_if.MDop = MD_NOP;
    cnt = 0;
    while (u_if.busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk({name, "_busy_cycles"}, 32'(cnt), 32'(exp_cyc));
  endtask

  // Called on a falling edge; returns on the next falling edge.
  task automatic check_hilo(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    chk({name, "_HI"}, u_if.HI, exp_hi);
    chk({name, "_LO"}, u_if.LO, exp_lo);
    u_if.MDop = MD_MFHI;
    #1;
    chk({name, "_mfhi"}, u_if.MDout, exp_hi);
    u_if.MDop = MD_MFLO;
    #1;
    chk({name, "_mflo"}, u_if.MDout, exp_lo);
    u_if.MDop = MD_NOP;
    @(negedge clk);
  endtask

  // Hazard contract: only nop/mfhi/mflo may be presented while busy.
  always begin
    @(negedge clk);
    #2;
    if (reset === 1'b1 && u_if.busy === 1'b1) begin
      checks++;
      if (!(u_if.MDop inside {MD_NOP, MD_MFHI, MD_MFLO}) && u_if.MDop < 4'd9) begin
        errors++;
        $display("FAIL busy_issue: MDop=%0d while busy, required nop/mfhi/mflo", u_if.MDop);
      end
    end
  end

  initial begin
    int cnt;
    vecs[0] = '{MD_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[1] = '{MD_MULTU, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA, 5};
    vecs[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3] = '{MD_DIVU,  32'd7,         32'd2,        32'd1,         32'd3,         10};
    vecs[4] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 10};
    vecs[5] = '{MD_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 5};
    vecs[6] = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 10};

    reset     = 1'b0;
    u_if.MDop = MD_NOP;
    u_if.A    = 32'd0;
    u_if.B    = 32'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy",  32'(u_if.busy),  32'd0);
    chk("rst_start", 32'(u_if.start), 32'd0);
    chk("rst_HI",    u_if.HI,         32'd0);
    chk("rst_LO",    u_if.LO,         32'd0);
    chk("rst_MDout", u_if.MDout,      32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_cyc);
      check_hilo($sformatf("vec%0d", i), vecs[i].exp_hi, vecs[i].exp_lo);
    end

    // mthi/mtlo then a divide by zero that must leave both untouched.
    u_if.MDop = MD_MTHI; u_if.A = 32'h0000_1234;
    @(negedge clk);
    chk("mthi_HI", u_if.HI, 32'h0000_1234);
    u_if.MDop = MD_MTLO; u_if.A = 32'h0000_55AA;
    @(negedge clk);
    chk("mtlo_LO", u_if.LO, 32'h0000_55AA);
    u_if.MDop = MD_NOP;
    run_op("divu0", MD_DIVU, 32'd9, 32'd0, 10);
    check_hilo("divu0", 32'h0000_1234, 32'h0000_55AA);

    // mflo during busy reads the old LO; the first cycle after busy reads the new one.
    u_if.MDop = MD_MULT; u_if.A = 32'd6; u_if.B = 32'd7;
    #1;
    chk("mflo_busy_start", 32'(u_if.start), 32'd1);
    @(negedge clk);
    u_if.MDop = MD_MFLO;
    #1;
    chk("mflo_during_busy", u_if.MDout, 32'h0000_55AA);
    cnt = 0;
    while (u_if.busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk("mflo_busy_cycles", 32'(cnt), 32'd5);
    #1;
    chk("mflo_after_busy", u_if.MDout, 32'd42);
    u_if.MDop = MD_NOP;
    @(negedge clk);

    // Back-to-back: each op issued in the first non-busy cycle.
    run_op("b2b_mult1", MD_MULT, 32'd3, 32'd4, 5);
    run_op("b2b_mult2", MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
    run_op("b2b_div",   MD_DIV,  32'd100, 32'd7, 10);
    check_hilo("b2b", 32'd2, 32'd14);

    // Reset in busy cycle 3 of a divide: abandoned, no later commit.
    u_if.MDop = MD_DIV; u_if.A = 32'd50; u_if.B = 32'd5;
    #1;
    chk("rstrun_start", 32'(u_if.start), 32'd1);
    @(negedge clk);
    u_if.MDop = MD_NOP;
    @(negedge clk);
    @(negedge clk);
    chk("rstrun_busy_before", 32'(u_if.busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("rstrun_busy", 32'(u_if.busy), 32'd0);
    chk("rstrun_HI",   u_if.HI,        32'd0);
    chk("rstrun_LO",   u_if.LO,        32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstrun_start_nop", 32'(u_if.start), 32'd0);
    repeat (15) @(negedge clk);
    chk("rstrun_late_busy", 32'(u_if.busy), 32'd0);
    chk("rstrun_late_HI",   u_if.HI,        32'd0);
    chk("rstrun_late_LO",   u_if.LO,        32'd0);
    u_if.MDop = MD_MULTU;
    #1;
    chk("rstrun_start_op", 32'(u_if.start), 32'd1);
    u_if.MDop = MD_NOP;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
